// File: rtl/rv32i_pipeline_ctrl_pkg.sv
// rtl/rv32i_pipeline_ctrl_pkg.sv - shared stage indices, flush masks and stall helper
package rv32i_pipeline_ctrl_pkg;

    localparam int NUM_STAGES         = 5;
    localparam int STAGE_FETCH        = 0;
    localparam int STAGE_DECODER      = 1;
    localparam int STAGE_ALU          = 2;
    localparam int STAGE_MEMORYACCESS = 3;
    localparam int STAGE_WRITEBACK    = 4;

    typedef logic [NUM_STAGES-1:0] stage_vec_t;

    // Branch in ALU squashes the two younger stages; a trap in WRITEBACK squashes all younger ones.
    localparam stage_vec_t ALU_FLUSH_MASK = 5'b00011;
    localparam stage_vec_t WB_FLUSH_MASK  = 5'b01111;

    // A stage stalls when it, or any older stage ahead of it, requests a stall.
    function automatic stage_vec_t backward_stall(input stage_vec_t req);
        stage_vec_t s;
        s[STAGE_WRITEBACK] = req[STAGE_WRITEBACK];
        for (int k = STAGE_WRITEBACK - 1; k >= STAGE_FETCH; k--) begin
            s[k] = req[k] | s[k+1];
        end
        return s;
    endfunction

endpackage

// File: rtl/rv32i_pipeline_ctrl_watchdog.sv
// rtl/rv32i_pipeline_ctrl_watchdog.sv - consecutive-stall counter with sticky timeout flag
module rv32i_stall_watchdog #(
    parameter int STALL_TIMEOUT = 255
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_stall,
    output logic o_timeout
);

    localparam logic [15:0] LIMIT = 16'(STALL_TIMEOUT);

    logic [15:0] cnt_q;
    logic        timeout_q;

    // Count consecutive stalled cycles, saturate at the limit, latch the flag until reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else if (!i_stall) begin
            cnt_q <= '0;
        end else if (cnt_q != LIMIT) begin
            cnt_q <= cnt_q + 16'd1;
            if (cnt_q == LIMIT - 16'd1) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign o_timeout = timeout_q;

endmodule

// File: rtl/rv32i_pipeline_ctrl.sv
// rtl/rv32i_pipeline_ctrl.sv - 5-stage stall/flush scheduler; optional perf counters under RV32I_PIPE_PERF_CNT_EN
module rv32i_pipeline_ctrl
    import rv32i_pipeline_ctrl_pkg::*;
#(
    parameter int STALL_TIMEOUT = 255
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_fetch_valid,
    input  logic [4:0]  i_stall_req,
    input  logic        i_alu_flush,
    input  logic        i_writeback_flush,
    output logic [4:0]  o_stage_ce,
    output logic [4:0]  o_stage_stall,
    output logic [4:0]  o_stage_flush,
    output logic        o_stall_timeout,
    output logic [31:0] o_stall_cycles,
    output logic [31:0] o_flush_count
);

    stage_vec_t valid_q;
    stage_vec_t valid_d;
    stage_vec_t stall;
    stage_vec_t flush;

    // Same-cycle stall propagation and flush mask union.
    always_comb begin
        stall = backward_stall(i_stall_req);
        flush = '0;
        if (i_alu_flush) begin
            flush = flush | ALU_FLUSH_MASK;
        end
        if (i_writeback_flush) begin
            flush = flush | WB_FLUSH_MASK;
        end
    end

    assign o_stage_flush = flush;
    assign o_stage_stall = stall & ~flush;
    assign o_stage_ce    = valid_q & ~flush & ~stall;

    // Next validity: flush kills, stall holds, otherwise take the younger stage's instruction.
    always_comb begin
        valid_d = valid_q;
        if (flush[STAGE_FETCH]) begin
            valid_d[STAGE_FETCH] = 1'b0;
        end else if (!stall[STAGE_FETCH]) begin
            valid_d[STAGE_FETCH] = i_fetch_valid;
        end
        for (int k = STAGE_DECODER; k <= STAGE_WRITEBACK; k++) begin
            if (flush[k]) begin
                valid_d[k] = 1'b0;
            end else if (!stall[k]) begin
                valid_d[k] = valid_q[k-1] & ~stall[k-1] & ~flush[k-1];
            end
        end
    end

    // Valid register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    rv32i_stall_watchdog #(
        .STALL_TIMEOUT(STALL_TIMEOUT)
    ) u_watchdog (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_stall  (stall[STAGE_FETCH]),
        .o_timeout(o_stall_timeout)
    );

`ifdef RV32I_PIPE_PERF_CNT_EN
    logic [31:0] stall_cycles_q;
    logic [31:0] flush_count_q;

    // Saturating counts of stalled cycles and flush cycles.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            if (|stall && stall_cycles_q != 32'hFFFF_FFFF) begin
                stall_cycles_q <= stall_cycles_q + 32'd1;
            end
            if ((i_alu_flush | i_writeback_flush) && flush_count_q != 32'hFFFF_FFFF) begin
                flush_count_q <= flush_count_q + 32'd1;
            end
        end
    end

    assign o_stall_cycles = stall_cycles_q;
    assign o_flush_count  = flush_count_q;
`else
    assign o_stall_cycles = 32'd0;
    assign o_flush_count  = 32'd0;
`endif

endmodule

// File: tb/tb_rv32i_pipeline_ctrl.sv
// tb/tb_rv32i_pipeline_ctrl.sv - self-checking bench for rv32i_pipeline_ctrl
module tb_rv32i_pipeline_ctrl;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_valid;
    logic [4:0]  stall_req;
    logic        alu_flush;
    logic        wb_flush;
    logic [4:0]  stage_ce;
    logic [4:0]  stage_stall;
    logic [4:0]  stage_flush;
    logic        stall_timeout;
    logic [31:0] stall_cycles;
    logic [31:0] flush_count;

    rv32i_pipeline_ctrl #(.STALL_TIMEOUT(TO)) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_fetch_valid    (fetch_valid),
        .i_stall_req      (stall_req),
        .i_alu_flush      (alu_flush),
        .i_writeback_flush(wb_flush),
        .o_stage_ce       (stage_ce),
        .o_stage_stall    (stage_stall),
        .o_stage_flush    (stage_flush),
        .o_stall_timeout  (stall_timeout),
        .o_stall_cycles   (stall_cycles),
        .o_flush_count    (flush_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // reference model: which stages hold an instruction, stall run length, sticky flag, perf counts
    bit          occ[5];
    int          stall_run;
    bit          to_flag;
    int unsigned m_stall_cyc;
    int unsigned m_flush_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // stage k is held if any request exists at k or any older stage
    function automatic bit m_stalled(int k);
        for (int j = k; j < 5; j++) if (stall_req[j]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_killed(int k);
        return (alu_flush && k <= 1) || (wb_flush && k <= 3);
    endfunction

    function automatic logic [4:0] exp_flush();
        logic [4:0] r;
        for (int k = 0; k < 5; k++) r[k] = m_killed(k);
        return r;
    endfunction

    function automatic logic [4:0] exp_stall();
        logic [4:0] r;
        for (int k = 0; k < 5; k++) r[k] = m_stalled(k) && !m_killed(k);
        return r;
    endfunction

    function automatic logic [4:0] exp_ce();
        logic [4:0] r;
        for (int k = 0; k < 5; k++) r[k] = occ[k] && !m_killed(k) && !m_stalled(k);
        return r;
    endfunction

    task automatic drive(input bit r, input bit fv, input logic [4:0] req, input bit af, input bit wf);
        @(negedge clk);
        rst = r; fetch_valid = fv; stall_req = req; alu_flush = af; wb_flush = wf;
        #1;
        check("ce", stage_ce, exp_ce());
        check("stall", stage_stall, exp_stall());
        check("flush", stage_flush, exp_flush());
        check("timeout", stall_timeout, to_flag);
`ifdef RV32I_PIPE_PERF_CNT_EN
        check("stall_cycles", stall_cycles, m_stall_cyc);
        check("flush_count", flush_count, m_flush_cnt);
`else
        check("stall_cycles", stall_cycles, 32'd0);
        check("flush_count", flush_count, 32'd0);
`endif
    endtask

    // advance one clock and move instructions forward in the model
    task automatic tick();
        bit nxt[5];
        @(posedge clk);
        if (rst) begin
            for (int k = 0; k < 5; k++) occ[k] = 0;
            stall_run = 0; to_flag = 0; m_stall_cyc = 0; m_flush_cnt = 0;
        end else begin
            for (int k = 0; k < 5; k++) begin
                if (m_killed(k))       nxt[k] = 0;
                else if (m_stalled(k)) nxt[k] = occ[k];
                else if (k == 0)       nxt[k] = fetch_valid;
                else                   nxt[k] = occ[k-1] && !m_stalled(k-1) && !m_killed(k-1);
            end
            for (int k = 0; k < 5; k++) occ[k] = nxt[k];
            if (stall_req != 0) begin
                stall_run = (stall_run < TO) ? stall_run + 1 : TO;
                m_stall_cyc++;
            end else begin
                stall_run = 0;
            end
            if (stall_run >= TO) to_flag = 1;
            if (alu_flush || wb_flush) m_flush_cnt++;
        end
    endtask

    initial begin
        logic [4:0] fill [5];
        fill[0] = 5'b00001; fill[1] = 5'b00011; fill[2] = 5'b00111;
        fill[3] = 5'b01111; fill[4] = 5'b11111;
        for (int k = 0; k < 5; k++) occ[k] = 0;
        stall_run = 0; to_flag = 0; m_stall_cyc = 0; m_flush_cnt = 0;
        rst = 1; fetch_valid = 0; stall_req = 0; alu_flush = 0; wb_flush = 0;

        // reset, then fill the pipe
        drive(1, 0, 5'b0, 0, 0); tick();
        drive(1, 1, 5'b0, 0, 0); tick();
        drive(0, 1, 5'b0, 0, 0);
        check("reset_ce", stage_ce, 5'b00000);
        check("reset_timeout", stall_timeout, 1'b0);
        tick();
        for (int i = 0; i < 5; i++) begin
            drive(0, 1, 5'b0, 0, 0);
            check("fill_ce", stage_ce, fill[i]);
            tick();
        end

        // one-cycle ALU force-stall inserts one bubble into MEMORYACCESS
        drive(0, 1, 5'b00100, 0, 0);
        check("alu_stall_stall", stage_stall, 5'b00111);
        check("alu_stall_ce", stage_ce, 5'b11000);
        tick();
        drive(0, 1, 5'b0, 0, 0); check("bubble_ce0", stage_ce, 5'b10111); tick();
        drive(0, 1, 5'b0, 0, 0); check("bubble_ce1", stage_ce, 5'b01111); tick();
        drive(0, 1, 5'b0, 0, 0); check("refill_ce", stage_ce, 5'b11111); tick();

        // ALU flush beats a FETCH stall request
        drive(0, 1, 5'b00001, 1, 0);
        check("aflush_flush", stage_flush, 5'b00011);
        check("aflush_stall", stage_stall, 5'b00000);
        check("aflush_ce", stage_ce, 5'b11100);
        tick();
        drive(0, 1, 5'b0, 0, 0); check("aflush_next", stage_ce, 5'b11000); tick();
        for (int i = 0; i < 4; i++) begin drive(0, 1, 5'b0, 0, 0); tick(); end
        drive(0, 1, 5'b0, 0, 0); check("refill2_ce", stage_ce, 5'b11111); tick();

        // writeback trap squashes everything younger
        drive(0, 1, 5'b0, 0, 1);
        check("wflush_flush", stage_flush, 5'b01111);
        check("wflush_ce", stage_ce, 5'b10000);
        tick();
        drive(0, 1, 5'b0, 0, 0); check("wflush_next", stage_ce, 5'b00000); tick();
        drive(0, 1, 5'b0, 0, 0); check("wflush_next2", stage_ce, 5'b00001); tick();

        // timeout: WRITEBACK stall held six cycles, flag sticky until reset
        drive(1, 0, 5'b0, 0, 0); tick();
        for (int i = 0; i < 6; i++) begin
            drive(0, 1, 5'b10000, 0, 0);
            check("to_hold", stall_timeout, (i >= TO) ? 1'b1 : 1'b0);
            tick();
        end
        drive(0, 1, 5'b0, 0, 0); check("to_sticky", stall_timeout, 1'b1); tick();
        drive(0, 1, 5'b0, 0, 0); check("to_sticky2", stall_timeout, 1'b1); tick();
        drive(1, 1, 5'b0, 0, 0); tick();
        drive(0, 1, 5'b0, 0, 0); check("to_cleared", stall_timeout, 1'b0); tick();

        // perf counters: 3 stall cycles + 2 flush cycles from reset
        drive(1, 1, 5'b0, 0, 0); tick();
        for (int i = 0; i < 3; i++) begin drive(0, 1, 5'b00010, 0, 0); tick(); end
        drive(0, 1, 5'b0, 1, 0); tick();
        drive(0, 1, 5'b0, 0, 1); tick();
        drive(0, 1, 5'b0, 0, 0);
`ifdef RV32I_PIPE_PERF_CNT_EN
        check("perf_stall", stall_cycles, 32'd3);
        check("perf_flush", flush_count, 32'd2);
`else
        check("perf_stall_off", stall_cycles, 32'd0);
        check("perf_flush_off", flush_count, 32'd0);
`endif
        tick();

        // randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            logic [4:0] req;
            for (int k = 0; k < 5; k++) req[k] = ($urandom_range(0, 7) == 0);
            drive(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0), req,
                  ($urandom_range(0, 9) == 0), ($urandom_range(0, 11) == 0));
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
